// File: rtl/dadda_mult_pipe.sv
// Pipelined WIDTH x WIDTH Dadda multiplier with per-operation signed (Baugh-Wooley) mode.
// Stages: operand capture -> partial products + Dadda reduction to two rows -> final add.
module dadda_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int P    = 2 * WIDTH;
  localparam int MAXH = WIDTH + 1;

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
  // Each stage may load whenever it is empty or its downstream stage is loading, so
  // bubbles collapse and in_ready never depends on a, b or in_valid.
  logic en1, en2, en3;
  logic v1, v2, v3;

  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_signed;
  logic [P-1:0]     row0, row1;
  logic [P-1:0]     s2_row0, s2_row1;

  function automatic int dadda_d(input int k);
    case (k)
      0:       dadda_d = 2;
      1:       dadda_d = 3;
      2:       dadda_d = 4;
      3:       dadda_d = 6;
      4:       dadda_d = 9;
      5:       dadda_d = 13;
      6:       dadda_d = 19;
      7:       dadda_d = 28;
      default: dadda_d = 42;
    endcase
  endfunction

  assign en3       = !v3 || out_ready;
  assign en2       = !v2 || en3;
  assign en1       = !v1 || en2;
  assign in_ready  = en1;
  assign out_valid = v3;
  assign busy      = v1 || v2 || v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_signed <= 1'b0;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_a      <= a;
        s1_b      <= b;
        s1_signed <= signed_mode;
      end
    end
  end

  // Column heights are data-independent, so every loop below folds to fixed adder wiring.
  always_comb begin : reduce
    logic col [P][MAXH];
    logic nxt [P][MAXH];
    int   cnt [P];
    int   ncnt [P];
    int   idx;
    int   h;
    int   d;
    logic x, y, z;

    idx = 0;
    h   = 0;
    d   = 0;
    x   = 1'b0;
    y   = 1'b0;
    z   = 1'b0;
    for (int c = 0; c < P; c++) begin
      cnt[c]  = 0;
      ncnt[c] = 0;
      for (int k = 0; k < MAXH; k++) begin
        col[c][k] = 1'b0;
        nxt[c][k] = 1'b0;
      end
    end

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        col[i+j][cnt[i+j]] = (s1_a[i] & s1_b[j]) ^
                             (s1_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
        cnt[i+j] = cnt[i+j] + 1;
      end
    end
    // Baugh-Wooley correction constants; a zero bit in unsigned mode keeps heights fixed.
    col[WIDTH][cnt[WIDTH]] = s1_signed;
    cnt[WIDTH] = cnt[WIDTH] + 1;
    col[P-1][cnt[P-1]] = s1_signed;
    cnt[P-1] = cnt[P-1] + 1;

    for (int st = 8; st >= 0; st--) begin
      d = dadda_d(st);
      if (d < WIDTH) begin
        for (int c = 0; c < P; c++) begin
          ncnt[c] = 0;
          for (int k = 0; k < MAXH; k++) nxt[c][k] = 1'b0;
        end
        for (int c = 0; c < P; c++) begin
          idx = 0;
          for (int k = 0; k < MAXH; k++) begin
            h = (cnt[c] - idx) + ncnt[c];
            if (h > d && (cnt[c] - idx) >= 2) begin
              x = col[c][idx];
              y = col[c][idx+1];
              if (h == d + 1 || (cnt[c] - idx) < 3) begin
                nxt[c][ncnt[c]] = x ^ y;
                ncnt[c] = ncnt[c] + 1;
                if (c + 1 < P) begin
                  nxt[c+1][ncnt[c+1]] = x & y;
                  ncnt[c+1] = ncnt[c+1] + 1;
                end
                idx = idx + 2;
              end else begin
                z = col[c][idx+2];
                nxt[c][ncnt[c]] = x ^ y ^ z;
                ncnt[c] = ncnt[c] + 1;
                if (c + 1 < P) begin
                  nxt[c+1][ncnt[c+1]] = (x & y) | (x & z) | (y & z);
                  ncnt[c+1] = ncnt[c+1] + 1;
                end
                idx = idx + 3;
              end
            end
          end
          for (int k = 0; k < MAXH; k++) begin
            if (k >= idx && k < cnt[c]) begin
              nxt[c][ncnt[c]] = col[c][k];
              ncnt[c] = ncnt[c] + 1;
            end
          end
        end
        col = nxt;
        cnt = ncnt;
      end
    end

    row0 = '0;
    row1 = '0;
    for (int c = 0; c < P; c++) begin
      row0[c] = col[c][0];
      row1[c] = col[c][1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      s2_row0 <= '0;
      s2_row1 <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        s2_row0 <= row0;
        s2_row1 <= row1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3      <= 1'b0;
      product <= '0;
    end else if (en3) begin
      v3 <= v2;
      if (v2) product <= s2_row0 + s2_row1;
    end
  end

endmodule
